prf_free_list: RTL

- Owns the pool of unallocated physical registers for the R10K-style PRF.
- Hands up to `N` free PRNs per cycle to dispatch/rename.
- Reclaims PRNs released at retirement.
- Drives the PRF `prn_invalid` port so each newly allocated entry is marked not-ready on the same edge it leaves the list.
- Restores allocation state on branch-mispredict squash using an architectural head pointer.

---
 rtl/prf_free_list_pkg.sv | 25 ++
 rtl/prf_free_list_free_compact.sv | 47 ++++
 rtl/prf_free_list.sv | 128 ++++++++++++
 3 files changed

// File: rtl/prf_free_list_pkg.sv
// prf_free_list_pkg
//   Shared sizing constants and types for the R10K-style physical register
//   free list. The top module derives its internal widths from its own
//   parameters, which default to the values below.
//   Contents:
//     N_WAY, PHYS_REG_SZ_R10K, ARCH_REG_SZ : default machine sizes
//     FL_SZ                                : free-list capacity
//     PRN / FL_PTR / FL_CNT                : PRN, pointer (index + wrap bit)
//                                            and occupancy-count types
package prf_free_list_pkg;

  localparam int unsigned N_WAY            = 3;
  localparam int unsigned PHYS_REG_SZ_R10K = 64;
  localparam int unsigned ARCH_REG_SZ      = 32;
  localparam int unsigned FL_SZ            = PHYS_REG_SZ_R10K - ARCH_REG_SZ;

  localparam int unsigned PRN_W    = $clog2(PHYS_REG_SZ_R10K);
  localparam int unsigned FL_PTR_W = $clog2(FL_SZ) + 1;
  localparam int unsigned FL_CNT_W = $clog2(FL_SZ + 1);

  typedef logic [PRN_W-1:0]    PRN;
  typedef logic [FL_PTR_W-1:0] FL_PTR;
  typedef logic [FL_CNT_W-1:0] FL_CNT;

endpackage

// File: rtl/prf_free_list_free_compact.sv
// free_compact
//   Combinational prefix-sum compactor. Every slot whose valid bit is set
//   and whose PRN is nonzero is packed, in slot order, into the low entries
//   of o_prn; o_cnt reports how many were packed. PRN 0 is the hardwired
//   register and is treated as "nothing to release".
//   Ports:
//     i_valid [N]        per-slot valid
//     i_prn   [N][PRN_W] per-slot PRN
//     o_prn   [N][PRN_W] dense PRNs, entries >= o_cnt are zero
//     o_cnt              number of packed entries
module free_compact
  import prf_free_list_pkg::*;
#(
  parameter int unsigned N     = N_WAY,
  parameter int unsigned PRN_W = $clog2(PHYS_REG_SZ_R10K)
) (
  input  logic [N-1:0]                 i_valid,
  input  logic [N-1:0][PRN_W-1:0]      i_prn,
  output logic [N-1:0][PRN_W-1:0]      o_prn,
  output logic [$clog2(N+1)-1:0]       o_cnt
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [N-1:0]  w_keep;
  logic [CW-1:0] w_off [N];

  // Exclusive prefix sum of kept slots gives each slot its dense position.
  always_comb begin
    o_cnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_keep[i] = i_valid[i] && (i_prn[i] != '0);
      w_off[i]  = o_cnt;
      if (w_keep[i]) o_cnt = o_cnt + CW'(1);
    end
  end

  always_comb begin
    o_prn = '0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (w_keep[i] && (w_off[i] == CW'(k))) o_prn[k] = i_prn[i];
      end
    end
  end

endmodule

// File: rtl/prf_free_list.sv
// prf_free_list
//   Circular-buffer pool of unallocated physical registers. Up to N PRNs are
//   offered per cycle straight from the head; granted PRNs are reported on
//   prn_invalid so the PRF clears their ready bit on the same edge. PRNs
//   released at retirement are compacted and appended at the tail. A squash
//   rewinds head to the architectural head (plus this cycle's retirements).
//   Ports:
//     clock, reset        rising-edge clock, async active-low reset
//     alloc_req   [N]     thermometer allocate request
//     alloc_prn   [N]     PRN offered to each slot (combinational)
//     alloc_avail         min(free_count, N)
//     prn_invalid [N]     granted PRN per slot, else 0
//     free_valid  [N]     retire free request per slot
//     free_prn    [N]     PRN released per slot (0 is ignored)
//     retire_alloc_cnt    retiring instructions that had allocated a PRN
//     squash              mispredict recovery
//     free_count          entries currently on the list
module prf_free_list
  import prf_free_list_pkg::*;
#(
  parameter int unsigned N       = N_WAY,
  parameter int unsigned PRF_SZ  = PHYS_REG_SZ_R10K,
  parameter int unsigned ARCH_SZ = ARCH_REG_SZ
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [N-1:0]                              alloc_req,
  output logic [N-1:0][$clog2(PRF_SZ)-1:0]          alloc_prn,
  output logic [$clog2(N+1)-1:0]                    alloc_avail,
  output logic [N-1:0][$clog2(PRF_SZ)-1:0]          prn_invalid,
  input  logic [N-1:0]                              free_valid,
  input  logic [N-1:0][$clog2(PRF_SZ)-1:0]          free_prn,
  input  logic [$clog2(N+1)-1:0]                    retire_alloc_cnt,
  input  logic                                      squash,
  output logic [$clog2(PRF_SZ-ARCH_SZ+1)-1:0]       free_count
);

  localparam int unsigned FLS  = PRF_SZ - ARCH_SZ;
  localparam int unsigned IW   = $clog2(FLS);
  localparam int unsigned PTRW = IW + 1;
  localparam int unsigned PW   = $clog2(PRF_SZ);
  localparam int unsigned CW   = $clog2(N + 1);

  logic [PW-1:0]   r_buf [FLS];
  logic [PTRW-1:0] r_head;
  logic [PTRW-1:0] r_tail;
  logic [PTRW-1:0] r_arch_head;

  logic [PTRW-1:0]        w_count;
  logic [CW-1:0]          w_avail;
  logic [CW-1:0]          w_req_cnt;
  logic [CW-1:0]          w_grants;
  logic [IW-1:0]          w_rd_idx [N];
  logic [IW-1:0]          w_wr_idx [N];
  logic [N-1:0][PW-1:0]   w_fprn;
  logic [CW-1:0]          w_fcnt;
  logic [PTRW-1:0]        w_head_nxt;

  // Wrap bit makes tail - head distinguish full from empty.
  assign w_count     = r_tail - r_head;
  assign free_count  = w_count;
  assign w_avail     = (w_count >= PTRW'(N)) ? CW'(N) : CW'(w_count);
  assign alloc_avail = w_avail;

  always_comb begin
    w_req_cnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (alloc_req[i]) w_req_cnt = w_req_cnt + CW'(1);
    end
  end

  // No grants while in reset or on a squash cycle.
  assign w_grants = (!reset || squash) ? '0 :
                    ((w_req_cnt < w_avail) ? w_req_cnt : w_avail);

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_rd_idx[i]    = r_head[IW-1:0] + IW'(i);
      w_wr_idx[i]    = r_tail[IW-1:0] + IW'(i);
      alloc_prn[i]   = r_buf[w_rd_idx[i]];
      prn_invalid[i] = (CW'(i) < w_grants) ? alloc_prn[i] : '0;
    end
  end

  free_compact #(
    .N     (N),
    .PRN_W (PW)
  ) u_free_compact (
    .i_valid (free_valid),
    .i_prn   (free_prn),
    .o_prn   (w_fprn),
    .o_cnt   (w_fcnt)
  );

  // Squash rewinds to the oldest unretired allocation; this cycle's
  // retirements are folded in since they are older than the squash.
  assign w_head_nxt = squash ? (r_arch_head + PTRW'(retire_alloc_cnt))
                             : (r_head + PTRW'(w_grants));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FLS; i++) begin
        r_buf[i] <= PW'(ARCH_SZ + i);
      end
      r_head      <= '0;
      r_arch_head <= '0;
      r_tail      <= PTRW'(FLS);
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (CW'(k) < w_fcnt) r_buf[w_wr_idx[k]] <= w_fprn[k];
      end
      r_head      <= w_head_nxt;
      r_tail      <= r_tail + PTRW'(w_fcnt);
      r_arch_head <= r_arch_head + PTRW'(retire_alloc_cnt);
    end
  end

  a_alloc_thermometer : assert property (
    @(posedge clock) disable iff (!reset)
      ((alloc_req & (alloc_req + N'(1))) == '0)
  );

  a_no_overflow : assert property (
    @(posedge clock) disable iff (!reset)
      ((32'(w_count) + 32'(w_fcnt)) <= FLS)
  );

endmodule
